// File: rtl/rca_multicycle_addsub.sv
// rca_multicycle_addsub
//   Multi-cycle ripple-carry adder/subtractor. A WIDTH-bit operation is
//   processed CHUNK bits per clock, least significant chunk first, with the
//   carry held in a register between cycles. This keeps the long carry chain
//   out of the critical path.
//
//   Parameters:
//     WIDTH  operand/result width; must be a multiple of CHUNK
//     CHUNK  bits added per clock (NCHUNK = WIDTH/CHUNK cycles per operation)
//
//   Ports:
//     clock       rising-edge clock
//     reset_n     asynchronous active-low reset
//     start       request a new operation (taken in IDLE or DONE)
//     sub         0 = add, 1 = subtract (latched with start)
//     in1, in2    operands (latched with start)
//     ci          carry-in / borrow-in (latched with start)
//     out         registered result
//     co          carry-out of MSB (in subtract mode 1 = no borrow)
//     ovf         signed overflow
//     busy        operation in progress
//     data_ready  one-cycle pulse when out/co/ovf update
//     dbg_state   current FSM state (0 IDLE, 1 RUN, 2 DONE)
//
//   Handshake: start is sampled at a rising edge. It is accepted only when
//   the FSM is not in RUN. Exactly NCHUNK edges after the accepting edge,
//   data_ready is high for one cycle together with the new out/co/ovf.
//
//   Optional feature: define RCA_MULTICYCLE_SAT_EN to clamp out to the
//   signed extreme on overflow. Without it the result wraps.

module rca_multicycle_addsub #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             ci,
    output logic [WIDTH-1:0] out,
    output logic             co,
    output logic             ovf,
    output logic             busy,
    output logic             data_ready,
    output logic [1:0]       dbg_state
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IW-1:0] LAST = IW'(NCHUNK - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0] a_q, b_q, acc_q;
    logic             carry_q;
    logic [IW-1:0]    idx_q;

    logic             accept, last;
    logic [CHUNK-1:0] a_ch, b_ch;
    logic [CHUNK:0]   ch_sum;
    logic [WIDTH-1:0] acc_nxt, res;
    logic             c_msb, ovf_nxt;

    assign accept    = start && (state != S_RUN);
    assign last      = (state == S_RUN) && (idx_q == LAST);
    assign dbg_state = state;

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_RUN;
            S_RUN:   if (idx_q == LAST) state_nxt = S_DONE;
            S_DONE:  state_nxt = start ? S_RUN : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // One chunk of the ripple adder, selected by the chunk index
    always_comb begin
        a_ch = '0;
        b_ch = '0;
        for (int k = 0; k < NCHUNK; k++) begin
            if (idx_q == IW'(k)) begin
                a_ch = a_q[k*CHUNK +: CHUNK];
                b_ch = b_q[k*CHUNK +: CHUNK];
            end
        end
        ch_sum  = {1'b0, a_ch} + {1'b0, b_ch} + {{CHUNK{1'b0}}, carry_q};
        acc_nxt = acc_q;
        for (int k = 0; k < NCHUNK; k++) begin
            if (idx_q == IW'(k)) acc_nxt[k*CHUNK +: CHUNK] = ch_sum[CHUNK-1:0];
        end
        // Carry into the top bit recovered from that bit's sum and operands;
        // only meaningful on the last chunk.
        c_msb   = ch_sum[CHUNK-1] ^ a_ch[CHUNK-1] ^ b_ch[CHUNK-1];
        ovf_nxt = c_msb ^ ch_sum[CHUNK];
        res     = acc_nxt;
`ifdef RCA_MULTICYCLE_SAT_EN
        // Overflow only happens when both addends share a sign, so the
        // sign of in1 tells which extreme the true result lies beyond.
        if (ovf_nxt) begin
            res = a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                               : {1'b0, {(WIDTH-1){1'b1}}};
        end
`else
`endif
    end

    // Datapath and result registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            a_q        <= '0;
            b_q        <= '0;
            acc_q      <= '0;
            carry_q    <= 1'b0;
            idx_q      <= '0;
            out        <= '0;
            co         <= 1'b0;
            ovf        <= 1'b0;
            busy       <= 1'b0;
            data_ready <= 1'b0;
        end else begin
            data_ready <= 1'b0;
            if (accept) begin
                // Subtract as in1 + ~in2 + ~ci, i.e. in1 - in2 - ci.
                a_q     <= in1;
                b_q     <= sub ? ~in2 : in2;
                carry_q <= ci ^ sub;
                idx_q   <= '0;
                busy    <= 1'b1;
            end else if (state == S_RUN) begin
                acc_q   <= acc_nxt;
                carry_q <= ch_sum[CHUNK];
                idx_q   <= idx_q + IW'(1);
                if (last) begin
                    out        <= res;
                    co         <= ch_sum[CHUNK];
                    ovf        <= ovf_nxt;
                    busy       <= 1'b0;
                    data_ready <= 1'b1;
                    idx_q      <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_rca_multicycle_addsub.sv
// Bench for rca_multicycle_addsub. Three instances: 32/8 (main), 16/16 and
// 16/4. Inputs are driven and outputs sampled on the falling clock edge.
module tb_rca_multicycle_addsub;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [2:0]  start_v, sub_v, ci_v;
    logic [31:0] in1_v [3];
    logic [31:0] in2_v [3];
    logic [31:0] out0;
    logic [15:0] out1, out2;
    logic [2:0]  co_v, ovf_v, busy_v, dr_v;
    logic [1:0]  st0, st1, st2;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];

`ifdef RCA_MULTICYCLE_SAT_EN
    localparam logic [31:0] OVF_ADD = 32'h7FFFFFFF;
    localparam logic [31:0] OVF_SUB = 32'h80000000;
    localparam logic [15:0] OVF16   = 16'h7FFF;
`else
    localparam logic [31:0] OVF_ADD = 32'h80000000;
    localparam logic [31:0] OVF_SUB = 32'h7FFFFFFF;
    localparam logic [15:0] OVF16   = 16'h8000;
`endif

    always #5 clock = ~clock;

    rca_multicycle_addsub #(.WIDTH(32), .CHUNK(8)) dut (
        .clock(clock), .reset_n(reset_n), .start(start_v[0]), .sub(sub_v[0]),
        .in1(in1_v[0]), .in2(in2_v[0]), .ci(ci_v[0]), .out(out0), .co(co_v[0]),
        .ovf(ovf_v[0]), .busy(busy_v[0]), .data_ready(dr_v[0]), .dbg_state(st0)
    );

    rca_multicycle_addsub #(.WIDTH(16), .CHUNK(16)) dut_w16c16 (
        .clock(clock), .reset_n(reset_n), .start(start_v[1]), .sub(sub_v[1]),
        .in1(in1_v[1][15:0]), .in2(in2_v[1][15:0]), .ci(ci_v[1]), .out(out1),
        .co(co_v[1]), .ovf(ovf_v[1]), .busy(busy_v[1]), .data_ready(dr_v[1]),
        .dbg_state(st1)
    );

    rca_multicycle_addsub #(.WIDTH(16), .CHUNK(4)) dut_w16c4 (
        .clock(clock), .reset_n(reset_n), .start(start_v[2]), .sub(sub_v[2]),
        .in1(in1_v[2][15:0]), .in2(in2_v[2][15:0]), .ci(ci_v[2]), .out(out2),
        .co(co_v[2]), .ovf(ovf_v[2]), .busy(busy_v[2]), .data_ready(dr_v[2]),
        .dbg_state(st2)
    );

    // Drive one start pulse. With now=0 it first moves to the next falling
    // edge. It returns at the falling edge just after the accepting edge.
    task automatic start_op(input int w, input logic now, input logic s,
                            input logic [31:0] a, input logic [31:0] b, input logic c);
        if (!now) @(negedge clock);
        sub_v[w] = s; in1_v[w] = a; in2_v[w] = b; ci_v[w] = c; start_v[w] = 1'b1;
        @(negedge clock);
        start_v[w] = 1'b0;
    endtask

    // Called just after the accepting edge. lat = edges from accept to
    // data_ready. bcnt = sampled cycles with busy high before that.
    task automatic wait_ready(input int w, output int lat, output int bcnt);
        lat = 0; bcnt = 0;
        while (!dr_v[w] && lat < 20) begin
            if (busy_v[w]) bcnt++;
            @(negedge clock);
            lat++;
        end
        if (!dr_v[w]) begin
            n_cmp++; n_err++;
            $display("FAIL timeout dut%0d: data_ready got 0 want 1 within 20 cycles", w);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; start_v = '0; sub_v = '0; ci_v = '0;
        for (int i = 0; i < 3; i++) begin in1_v[i] = '0; in2_v[i] = '0; end
        repeat (2) @(negedge clock);
        n_cmp++; if (out0 !== 32'h0) begin n_err++; $display("FAIL reset_out got %h want 0", out0); end
        n_cmp++; if (co_v !== 3'b0) begin n_err++; $display("FAIL reset_co got %b want 000", co_v); end
        n_cmp++; if (ovf_v !== 3'b0) begin n_err++; $display("FAIL reset_ovf got %b want 000", ovf_v); end
        n_cmp++; if (busy_v !== 3'b0) begin n_err++; $display("FAIL reset_busy got %b want 000", busy_v); end
        n_cmp++; if (dr_v !== 3'b0) begin n_err++; $display("FAIL reset_dr got %b want 000", dr_v); end
        n_cmp++; if (st0 !== 2'd0) begin n_err++; $display("FAIL reset_state got %0d want 0", st0); end
        reset_n = 1'b1;
    endtask

    task automatic test_add_ripple();
        int lat, bcnt;
        start_op(0, 1'b0, 1'b0, 32'h0000FFFF, 32'h00000001, 1'b0);
        n_cmp++; if (out0 !== 32'h0) begin n_err++; $display("FAIL add_hold got %h want 0", out0); end
        wait_ready(0, lat, bcnt);
        n_cmp++; if (out0 !== 32'h00010000) begin n_err++; $display("FAIL add_out got %h want 00010000", out0); end
        n_cmp++; if (co_v[0] !== 1'b0) begin n_err++; $display("FAIL add_co got %b want 0", co_v[0]); end
        n_cmp++; if (ovf_v[0] !== 1'b0) begin n_err++; $display("FAIL add_ovf got %b want 0", ovf_v[0]); end
        n_cmp++; if (lat != 4) begin n_err++; $display("FAIL add_latency got %0d want 4", lat); end
        n_cmp++; if (bcnt != 4) begin n_err++; $display("FAIL add_busy_cycles got %0d want 4", bcnt); end
        @(negedge clock);
        n_cmp++; if (dr_v[0] !== 1'b0) begin n_err++; $display("FAIL add_dr_pulse got %b want 0", dr_v[0]); end
    endtask

    task automatic test_overflow();
        int lat, bcnt;
        start_op(0, 1'b0, 1'b0, 32'h7FFFFFFF, 32'h00000001, 1'b0);
        wait_ready(0, lat, bcnt);
        n_cmp++; if (out0 !== OVF_ADD) begin n_err++; $display("FAIL ovf_out got %h want %h", out0, OVF_ADD); end
        n_cmp++; if (ovf_v[0] !== 1'b1) begin n_err++; $display("FAIL ovf_flag got %b want 1", ovf_v[0]); end
        n_cmp++; if (co_v[0] !== 1'b0) begin n_err++; $display("FAIL ovf_co got %b want 0", co_v[0]); end
    endtask

    task automatic test_subtract();
        int lat, bcnt;
        start_op(0, 1'b0, 1'b1, 32'd5, 32'd7, 1'b0);
        wait_ready(0, lat, bcnt);
        n_cmp++; if (out0 !== 32'hFFFFFFFE) begin n_err++; $display("FAIL sub1_out got %h want fffffffe", out0); end
        n_cmp++; if ({co_v[0], ovf_v[0]} !== 2'b00) begin n_err++; $display("FAIL sub1_flags got %b want 00", {co_v[0], ovf_v[0]}); end
        start_op(0, 1'b0, 1'b1, 32'h80000000, 32'd1, 1'b0);
        wait_ready(0, lat, bcnt);
        n_cmp++; if (out0 !== OVF_SUB) begin n_err++; $display("FAIL sub2_out got %h want %h", out0, OVF_SUB); end
        n_cmp++; if ({co_v[0], ovf_v[0]} !== 2'b11) begin n_err++; $display("FAIL sub2_flags got %b want 11", {co_v[0], ovf_v[0]}); end
        start_op(0, 1'b0, 1'b1, 32'd10, 32'd3, 1'b1);
        wait_ready(0, lat, bcnt);
        n_cmp++; if (out0 !== 32'd6) begin n_err++; $display("FAIL sub3_out got %h want 6", out0); end
        n_cmp++; if (co_v[0] !== 1'b1) begin n_err++; $display("FAIL sub3_co got %b want 1", co_v[0]); end
    endtask

    task automatic test_start_ignored();
        int lat, bcnt;
        start_op(0, 1'b0, 1'b0, 32'd1, 32'd2, 1'b0);
        start_op(0, 1'b1, 1'b1, 32'h100, 32'h200, 1'b1);
        n_cmp++; if (out0 !== 32'd6) begin n_err++; $display("FAIL ign_hold got %h want 6", out0); end
        n_cmp++; if (busy_v[0] !== 1'b1) begin n_err++; $display("FAIL ign_busy got %b want 1", busy_v[0]); end
        wait_ready(0, lat, bcnt);
        n_cmp++; if (out0 !== 32'd3) begin n_err++; $display("FAIL ign_out got %h want 3", out0); end
    endtask

    task automatic test_back_to_back();
        int lat, bcnt;
        logic [31:0] e;
        exp_q.push_back(32'h33333333);
        exp_q.push_back(32'h10101010);
        start_op(0, 1'b0, 1'b0, 32'h11111111, 32'h22222222, 1'b0);
        wait_ready(0, lat, bcnt);
        e = exp_q.pop_front();
        n_cmp++; if (out0 !== e) begin n_err++; $display("FAIL b2b_first got %h want %h", out0, e); end
        n_cmp++; if (st0 !== 2'd2) begin n_err++; $display("FAIL b2b_done_state got %0d want 2", st0); end
        start_op(0, 1'b1, 1'b0, 32'h0F0F0F0F, 32'h01010101, 1'b0);
        n_cmp++; if (out0 !== e) begin n_err++; $display("FAIL b2b_hold got %h want %h", out0, e); end
        n_cmp++; if (busy_v[0] !== 1'b1) begin n_err++; $display("FAIL b2b_busy got %b want 1", busy_v[0]); end
        wait_ready(0, lat, bcnt);
        e = exp_q.pop_front();
        n_cmp++; if (out0 !== e) begin n_err++; $display("FAIL b2b_second got %h want %h", out0, e); end
        n_cmp++; if (lat != 4) begin n_err++; $display("FAIL b2b_latency got %0d want 4", lat); end
    endtask

    task automatic test_reset_mid();
        int lat, bcnt;
        logic seen;
        start_op(0, 1'b0, 1'b0, 32'h12345678, 32'd1, 1'b0);
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        n_cmp++; if (out0 !== 32'h0) begin n_err++; $display("FAIL rst_out got %h want 0", out0); end
        n_cmp++; if ({co_v[0], ovf_v[0], busy_v[0]} !== 3'b000) begin n_err++; $display("FAIL rst_flags got %b want 000", {co_v[0], ovf_v[0], busy_v[0]}); end
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            if (i == 1) reset_n = 1'b1;
            if (dr_v[0]) seen = 1'b1;
        end
        n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL rst_no_ready got %b want 0", seen); end
        start_op(0, 1'b0, 1'b0, 32'hFFFFFFFF, 32'd1, 1'b0);
        wait_ready(0, lat, bcnt);
        n_cmp++; if (out0 !== 32'h0) begin n_err++; $display("FAIL rst_next_out got %h want 0", out0); end
        n_cmp++; if ({co_v[0], ovf_v[0]} !== 2'b10) begin n_err++; $display("FAIL rst_next_flags got %b want 10", {co_v[0], ovf_v[0]}); end
    endtask

    task automatic test_narrow();
        int lat, bcnt;
        start_op(1, 1'b0, 1'b0, 32'h0000FFFF, 32'h00000001, 1'b0);
        wait_ready(1, lat, bcnt);
        n_cmp++; if (out1 !== 16'h0000) begin n_err++; $display("FAIL c16_out got %h want 0000", out1); end
        n_cmp++; if (co_v[1] !== 1'b1) begin n_err++; $display("FAIL c16_co got %b want 1", co_v[1]); end
        n_cmp++; if (lat != 1) begin n_err++; $display("FAIL c16_latency got %0d want 1", lat); end
        start_op(2, 1'b0, 1'b0, 32'h00007FFF, 32'h00000001, 1'b0);
        wait_ready(2, lat, bcnt);
        n_cmp++; if (ovf_v[2] !== 1'b1) begin n_err++; $display("FAIL c4_ovf got %b want 1", ovf_v[2]); end
        n_cmp++; if (co_v[2] !== 1'b0) begin n_err++; $display("FAIL c4_co got %b want 0", co_v[2]); end
        n_cmp++; if (out2 !== OVF16) begin n_err++; $display("FAIL c4_out got %h want %h", out2, OVF16); end
        n_cmp++; if (lat != 4) begin n_err++; $display("FAIL c4_latency got %0d want 4", lat); end
    endtask

    initial begin
        test_reset();
        test_add_ripple();
        test_overflow();
        test_subtract();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid();
        test_narrow();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/rca_multicycle_addsub.md
Name: rca_multicycle_addsub

Overview:
- Parametrised multi-cycle ripple-carry adder/subtractor.
- Processes a WIDTH-bit operation CHUNK bits per clock, LSB chunk first, with the carry held in a register between cycles.
- Successor to the fixed-width combinational ripple-carry adder. Adds a generic width, selectable slice size, subtract mode and a start/busy/data_ready handshake.
- Sits beside the ALU/multdiv path where long carry chains must not set the clock period.

Parameters:
- WIDTH, 32, operand/result width in bits. Must be a multiple of CHUNK.
- CHUNK, 8, bits added per cycle. NCHUNK = WIDTH/CHUNK; NCHUNK ≥ 1.

Ports:
- clock  input  1  single clock; rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  request a new operation; sampled at rising edge.
- sub  input  1  0 = add, 1 = subtract; latched with start.
- in1  input  WIDTH  operand A; latched with start.
- in2  input  WIDTH  operand B; latched with start.
- ci  input  1  carry-in (add) / borrow-in (sub); latched with start.
- out  output  WIDTH  result; registered.
- co  output  1  carry-out of MSB; in sub mode 1 = no borrow.
- ovf  output  1  signed (two's complement) overflow.
- busy  output  1  high while an operation is in progress.
- data_ready  output  1  one-cycle pulse when out/co/ovf update.

Behaviour:
- Reset (reset_n = 0, asynchronous): state IDLE; out=0, co=0, ovf=0, busy=0, data_ready=0; chunk index and carry register cleared.
- States: IDLE, RUN, DONE. DONE lasts exactly one cycle, then returns to IDLE unless a new start is taken.
- Accept: start=1 at an edge while state is IDLE or DONE.
  - Latch A=in1, B = sub ? ~in2 : in2, carry = ci XOR sub.
  - Clear index to 0, go to RUN, busy=1 from the next cycle.
  - Subtract therefore computes in1 − in2 − ci.
- start while in RUN is ignored; operands are not re-latched.
- RUN, edge k (k = 1..NCHUNK): add chunk k−1 of A and B plus the carry register. Write the sum bits to an internal accumulator and update the carry.
  - Carry into the MSB is captured on the last chunk.
- Completion at edge NCHUNK after the accepting edge:
  - out <= accumulator; co <= final carry; ovf <= carry-into-MSB XOR carry-out-of-MSB.
  - busy <= 0; data_ready <= 1 for exactly one cycle; state DONE.
- Latency: exactly NCHUNK cycles from the accepting edge to data_ready high. CHUNK == WIDTH gives latency 1.
- out/co/ovf change only at completion. They hold the previous result during RUN and until the next completion.
- start in the DONE cycle is accepted, giving back-to-back throughput of one result per NCHUNK cycles.
- Reset mid-RUN aborts the operation: no data_ready, outputs forced to reset values.
- Arithmetic is modulo 2^WIDTH. No internal width extension beyond the carry bit.

Optional Feature:
- Macro: RCA_MULTICYCLE_SAT_EN
- Defined: on signed overflow at completion, out is clamped.
  - Clamp value is 2^(WIDTH−1)−1 if the true result is positive (in1 MSB = 0), else 2^(WIDTH−1) as unsigned pattern.
  - ovf and co are still reported unmodified.
- Undefined: out wraps modulo 2^WIDTH. No saturation logic is present.

Test Plan (WIDTH=32, CHUNK=8 unless stated):
- Add ripple: in1=0x0000FFFF, in2=0x00000001, ci=0, sub=0 -> out=0x00010000, co=0, ovf=0; data_ready exactly 4 cycles after the accepting edge; busy high for 4 cycles.
- Signed overflow: in1=0x7FFFFFFF, in2=0x00000001 -> ovf=1, co=0. Without SAT_EN out=0x80000000; with SAT_EN out=0x7FFFFFFF.
- Subtract: 5−7, ci=0 -> out=0xFFFFFFFE, co=0, ovf=0. 0x80000000−1 -> ovf=1, co=1; out=0x7FFFFFFF, or 0x80000000 with SAT_EN. 10−3 with ci=1 -> out=6, co=1.
- Handshake:
  - start with new operands during RUN -> ignored; first result unchanged.
  - start asserted in the data_ready cycle -> second result 4 cycles later; out holds the first result meanwhile.
- Reset mid-op: drop reset_n at the 2nd RUN cycle -> out=0, co=0, ovf=0, busy=0, no data_ready. Next operation 0xFFFFFFFF+1 -> out=0, co=1, ovf=0.
- WIDTH=16, CHUNK=16: 0xFFFF+0x0001 -> out=0x0000, co=1, latency 1 cycle. WIDTH=16, CHUNK=4: 0x7FFF+0x0001 -> ovf=1, latency 4.
